// File: rtl/clk_rst_mgr_pkg.sv
// Shared FSM encodings and sizing helpers for the clock-enable / reset manager.
package clk_rst_mgr_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // The sequencing counter has to reach both the lock qualification limit
  // and the last channel's release offset.
  function automatic int seq_cnt_width(input int lock_cyc, input int nch, input int stagger);
    int m;
    m = (lock_cyc > (nch - 1) * stagger + 1) ? lock_cyc : (nch - 1) * stagger + 1;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One channel divider: ce_o pulses every div+1 cycles once enabled, shadow retune at wrap.
// ce_o is combinational from registers; no backpressure.
module clk_en_div #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] div_i,
  input  logic [DW-1:0] phase_i,
  input  logic          cfg_load,
  output logic          ce_o
);

  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] ph_q, ph_d;
  logic [DW-1:0] sdiv_q, sdiv_d;
  logic [DW-1:0] sph_q, sph_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == div_q);
  assign ce_o = en & wrap;

  always_comb begin
    div_d  = div_q;
    ph_d   = ph_q;
    sdiv_d = sdiv_q;
    sph_d  = sph_q;
    cnt_d  = cnt_q;
    if (!en) begin
      div_d  = div_i;
      ph_d   = phase_i;
      sdiv_d = div_i;
      sph_d  = phase_i;
      cnt_d  = (phase_i < div_i) ? phase_i : div_i;
    end else begin
      // Active settings only change at the wrap so no period is ever cut short.
      if (wrap) begin
        cnt_d = '0;
        div_d = sdiv_q;
        ph_d  = sph_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cfg_load) begin
        sdiv_d = div_i;
        sph_d  = phase_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      ph_q   <= '0;
      sdiv_q <= '0;
      sph_q  <= '0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      ph_q   <= ph_d;
      sdiv_q <= sdiv_d;
      sph_q  <= sph_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_rst_mgr.sv
// Lock synchroniser, qualification FSM and staggered per-channel reset release
// feeding NCH programmable clock-enable dividers; lock loss drops all channels in one edge.
module clk_rst_mgr
  import clk_rst_mgr_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int DW          = 8,
  parameter int LOCK_CYC    = 1024,
  parameter int STAGGER     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic [NCH*DW-1:0] div_i,
  input  logic [NCH*DW-1:0] phase_i,
  input  logic              cfg_load,
  output logic [NCH-1:0]    ce_o,
  output logic [NCH-1:0]    rst_n_o,
  output logic              locked,
  output logic [1:0]        state_o
);

  localparam int SW = seq_cnt_width(LOCK_CYC, NCH, STAGGER);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_CYC - 1);
  localparam logic [SW-1:0] RELEASE_LAST = SW'((NCH - 1) * STAGGER);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [SW-1:0]          seq_cnt_q, seq_cnt_d;
  logic [NCH-1:0]         rst_out_q, rst_out_d;
  logic                   lock_s;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], pll_lock};
  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign rst_n_o = rst_out_q;
  assign locked  = (state_q == ST_RUN);
  assign state_o = state_q;

  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    rst_out_d = rst_out_q;
    if (state_q != ST_WAIT_LOCK && !lock_s) begin
      state_d   = ST_WAIT_LOCK;
      seq_cnt_d = '0;
      rst_out_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          seq_cnt_d = '0;
          rst_out_d = '0;
          if (lock_s) state_d = ST_STABLE;
        end
        ST_STABLE: begin
          if (seq_cnt_q == STABLE_LAST) begin
            state_d   = ST_RELEASE;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          seq_cnt_d = seq_cnt_q + 1'b1;
          for (int k = 0; k < NCH; k++) begin
            if (seq_cnt_q == SW'(k * STAGGER)) rst_out_d[k] = 1'b1;
          end
          if (seq_cnt_q == RELEASE_LAST) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= ST_WAIT_LOCK;
      seq_cnt_q <= '0;
      rst_out_q <= '0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      rst_out_q <= rst_out_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    clk_en_div #(.DW(DW)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (rst_out_q[k]),
      .div_i    (div_i[k*DW +: DW]),
      .phase_i  (phase_i[k*DW +: DW]),
      .cfg_load (cfg_load),
      .ce_o     (ce_o[k])
    );
  end

endmodule

// File: tb/tb_clk_rst_mgr.sv
// Bench for clk_rst_mgr: directed bring-up / retune / lock-loss timeline plus randomized
// traffic, all compared every cycle against a lock-history and countdown model.
module tb_clk_rst_mgr;

  localparam int NCH = 3;
  localparam int DW = 8;
  localparam int LOCK_CYC = 16;
  localparam int STAGGER = 4;
  localparam int SYNC = 2;
  localparam int RUN_H = LOCK_CYC + 2 + (NCH - 1) * STAGGER;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pll_lock;
  logic [NCH*DW-1:0] div_i;
  logic [NCH*DW-1:0] phase_i;
  logic              cfg_load;
  logic [NCH-1:0]    ce_o;
  logic [NCH-1:0]    rst_n_o;
  logic              locked;
  logic [1:0]        state_o;

  clk_rst_mgr #(
    .NCH(NCH), .DW(DW), .LOCK_CYC(LOCK_CYC), .STAGGER(STAGGER), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .div_i(div_i), .phase_i(phase_i),
    .cfg_load(cfg_load), .ce_o(ce_o), .rst_n_o(rst_n_o), .locked(locked), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int e = 0;

  // Model: h counts consecutive edges with synchronised lock high; everything
  // about the sequencer follows from h. Channels are modelled as countdowns to the next pulse.
  bit lock_q[$];
  int h = 0;
  bit m_en[NCH];
  int m_rem[NCH];
  int m_pend[NCH];
  logic [1:0]     x_state = 2'd0;
  logic           x_locked = 1'b0;
  logic [NCH-1:0] x_rst = '0;
  logic [NCH-1:0] x_ce = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit ls;
    bit new_en;
    int d, p;
    if (!rst_n) begin
      lock_q = {};
      for (int i = 0; i < SYNC; i++) lock_q.push_back(1'b0);
      h = 0;
      for (int k = 0; k < NCH; k++) begin
        m_en[k] = 1'b0; m_rem[k] = 0; m_pend[k] = 0;
      end
    end else begin
      ls = lock_q.pop_front();
      lock_q.push_back(pll_lock);
      h = ls ? ((h < 1000000) ? h + 1 : h) : 0;
      for (int k = 0; k < NCH; k++) begin
        d = int'(div_i[k*DW +: DW]);
        p = int'(phase_i[k*DW +: DW]);
        new_en = (h >= LOCK_CYC + 2 + k * STAGGER);
        if (!new_en) begin
          m_en[k] = 1'b0;
        end else if (!m_en[k]) begin
          m_en[k] = 1'b1;
          m_pend[k] = d;
          m_rem[k] = d - ((p < d) ? p : d);
        end else begin
          if (m_rem[k] == 0) m_rem[k] = m_pend[k];
          else m_rem[k] = m_rem[k] - 1;
          if (cfg_load) m_pend[k] = d;
        end
      end
    end
    x_state = (h == 0) ? 2'd0 : (h <= LOCK_CYC) ? 2'd1 : (h < RUN_H) ? 2'd2 : 2'd3;
    x_locked = (x_state == 2'd3);
    for (int k = 0; k < NCH; k++) begin
      x_rst[k] = m_en[k];
      x_ce[k] = m_en[k] && (m_rem[k] == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) lock_q.push_back(1'b0);
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("state_o", 32'(state_o), 32'(x_state));
        check("locked", 32'(locked), 32'(x_locked));
        check("rst_n_o", 32'(rst_n_o), 32'(x_rst));
        check("ce_o", 32'(ce_o), 32'(x_ce));
      end
    end
  end

  task automatic goto(input int n);
    while (e < n) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  initial begin
    int drop_left;
    int n;
    rst_n = 1'b0;
    pll_lock = 1'b1;
    cfg_load = 1'b0;
    div_i = {8'd9, 8'd0, 8'd4};
    phase_i = {8'd3, 8'd0, 8'd1};
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_rstn", 32'(rst_n_o), 32'd0);
    check("rst_ce", 32'(ce_o), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    pll_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 pll_lock = 1'b1;
    e = 0;

    // Nominal bring-up and channel divide/phase.
    goto(2);   check("wait_at2", 32'(state_o), 32'd0);
    goto(3);   check("stable_at3", 32'(state_o), 32'd1);
    goto(18);  check("stable_at18", 32'(state_o), 32'd1);
    goto(19);  check("release_at19", 32'(state_o), 32'd2);
               check("rst_at19", 32'(rst_n_o), 32'd0);
    goto(20);  check("rst_at20", 32'(rst_n_o), 32'd1);
    goto(22);  check("ce0_at22", 32'(ce_o[0]), 32'd0);
    goto(23);  check("ce0_at23", 32'(ce_o[0]), 32'd1);
               check("rst_at23", 32'(rst_n_o), 32'd1);
    goto(24);  check("rst_at24", 32'(rst_n_o), 32'd3);
    goto(25);  check("ce1_at25", 32'(ce_o[1]), 32'd1);
    goto(27);  check("locked_at27", 32'(locked), 32'd0);
    goto(28);  check("rst_at28", 32'(rst_n_o), 32'd7);
               check("locked_at28", 32'(locked), 32'd1);
               check("ce0_at28", 32'(ce_o[0]), 32'd1);
    goto(34);  check("ce2_at34", 32'(ce_o[2]), 32'd1);
    goto(44);  check("ce2_at44", 32'(ce_o[2]), 32'd1);

    // Retune channel 2 mid-period.
    goto(46);  cfg_load = 1'b1; div_i = {8'd2, 8'd0, 8'd4};
    goto(47);  cfg_load = 1'b0;
    goto(50);  check("ce2_at50", 32'(ce_o[2]), 32'd0);
    goto(54);  check("ce2_at54", 32'(ce_o[2]), 32'd1);
    goto(56);  check("ce2_at56", 32'(ce_o[2]), 32'd0);
    goto(57);  check("ce2_at57", 32'(ce_o[2]), 32'd1);
    goto(60);  check("ce2_at60", 32'(ce_o[2]), 32'd1);

    // One-cycle lock drop in RUN.
    goto(70);  pll_lock = 1'b0;
    goto(71);  pll_lock = 1'b1;
    goto(72);  check("rst_at72", 32'(rst_n_o), 32'd7);
               check("locked_at72", 32'(locked), 32'd1);
    goto(73);  check("rst_at73", 32'(rst_n_o), 32'd0);
               check("locked_at73", 32'(locked), 32'd0);
               check("state_at73", 32'(state_o), 32'd0);
               check("ce_at73", 32'(ce_o), 32'd0);
    goto(74);  check("state_at74", 32'(state_o), 32'd1);

    // Lock loss during STABLE at seq_cnt 10.
    goto(82);  pll_lock = 1'b0;
    goto(84);  check("state_at84", 32'(state_o), 32'd1);
    goto(85);  check("state_at85", 32'(state_o), 32'd0);
               pll_lock = 1'b1;
    goto(87);  check("state_at87", 32'(state_o), 32'd0);
    goto(88);  check("state_at88", 32'(state_o), 32'd1);
    goto(104); check("state_at104", 32'(state_o), 32'd2);
               check("rst_at104", 32'(rst_n_o), 32'd0);
    goto(105); check("rst_at105", 32'(rst_n_o), 32'd1);
    goto(109); check("rst_at109", 32'(rst_n_o), 32'd3);

    // Lock loss during RELEASE coinciding with the last channel's release slot.
    goto(110); pll_lock = 1'b0;
    goto(112); check("rst_at112", 32'(rst_n_o), 32'd3);
    goto(113); check("rst_at113", 32'(rst_n_o), 32'd0);
               check("state_at113", 32'(state_o), 32'd0);
               pll_lock = 1'b1;
    goto(132); check("rst_at132", 32'(rst_n_o), 32'd0);
    goto(133); check("rst_at133", 32'(rst_n_o), 32'd1);

    // Randomized traffic; the per-cycle compare does the checking.
    drop_left = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) pll_lock = 1'b1;
      end else if ($urandom_range(0, 119) == 0) begin
        pll_lock = 1'b0;
        drop_left = $urandom_range(1, 5);
      end
      rst_n = ($urandom_range(0, 599) != 0);
      cfg_load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) begin
        for (int k = 0; k < NCH; k++) begin
          div_i[k*DW +: DW] = DW'($urandom_range(0, 12));
          phase_i[k*DW +: DW] = DW'($urandom_range(0, 15));
        end
      end
    end

    // Synchronous reset while running.
    rst_n = 1'b1;
    pll_lock = 1'b1;
    cfg_load = 1'b0;
    n = 0;
    while (!locked && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("final_locked", 32'(locked), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstn_run_rst", 32'(rst_n_o), 32'd0);
    check("rstn_run_ce", 32'(ce_o), 32'd0);
    check("rstn_run_locked", 32'(locked), 32'd0);
    check("rstn_run_state", 32'(state_o), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rstn_hold_state", 32'(state_o), 32'd0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
